// File: rtl/match_ctrl_pkg.sv
// Shared state encoding and parameter defaults for the match controller slice.
package match_ctrl_pkg;

    localparam int NUM_CH_DEF   = 4;
    localparam int HIT_W_DEF    = 32;
    localparam int WEIGHT_W_DEF = 4;
    localparam int COMP_LAT_DEF = 4;
    localparam int WAIT_CNT_W   = 4;

    typedef enum logic [3:0] {
        ST_LOAD_CFG,
        ST_IDLE,
        ST_LOAD_FIFO,
        ST_COMPARE,
        ST_WAIT,
        ST_DECIDE,
        ST_STORE,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/match_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/match_controller.sv
// Packet match controller: sequences FIFO drain, comparator wait and weighted
// store decision, and keeps saturating per-channel hit and stored-packet counts.
module match_controller
    import match_ctrl_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int HIT_W    = HIT_W_DEF,
    parameter int WEIGHT_W = WEIGHT_W_DEF,
    parameter int COMP_LAT = COMP_LAT_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       update_done,
    input  logic                       ready,
    input  logic                       eop,
    input  logic                       error,
    input  logic                       rdempty,
    input  logic [NUM_CH-1:0]          match,
    input  logic [NUM_CH*WEIGHT_W-1:0] ch_weight,
    input  logic [WEIGHT_W+3:0]        threshold,
    input  logic [3:0]                 hit_sel,
    input  logic                       hit_clr,
    output logic                       rdreq,
    output logic                       inc_addr,
    output logic                       addr,
    output logic                       clear,
    output logic [HIT_W-1:0]           hit_count,
    output logic [HIT_W-1:0]           pkt_stored,
    output logic                       busy
);

    localparam int SUM_W = WEIGHT_W + 4;

    state_t                  state;
    state_t                  next_state;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic [SUM_W-1:0]        weighted_sum;
    logic [NUM_CH-1:0]       hit_inc;
    logic [NUM_CH-1:0]       hit_clr_ch;
    logic [HIT_W-1:0]        hit_cnt [NUM_CH];

    // Four extra bits cover up to 16 channels at full weight without overflow.
    always_comb begin
        weighted_sum = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (match[i]) begin
                weighted_sum = weighted_sum + SUM_W'(ch_weight[i*WEIGHT_W +: WEIGHT_W]);
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_LOAD_CFG:  if (update_done) next_state = ST_IDLE;
            ST_IDLE:      if (ready) next_state = ST_LOAD_FIFO;
            ST_LOAD_FIFO: begin
                if (eop)        next_state = ST_COMPARE;
                else if (error) next_state = ST_ERROR;
            end
            ST_COMPARE:   if (rdempty) next_state = ST_WAIT;
            ST_WAIT:      if (wait_cnt == '0) next_state = ST_DECIDE;
            ST_DECIDE:    next_state = (weighted_sum >= threshold) ? ST_STORE : ST_IDLE;
            ST_STORE:     next_state = ST_IDLE;
            ST_ERROR:     if (eop) next_state = ST_IDLE;
            default:      next_state = ST_LOAD_CFG;
        endcase
    end

    // Outputs decode next_state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_LOAD_CFG;
            addr     <= 1'b1;
            rdreq    <= 1'b0;
            inc_addr <= 1'b0;
            clear    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            addr     <= (next_state == ST_LOAD_CFG);
            clear    <= (next_state == ST_IDLE) || (next_state == ST_DECIDE);
            rdreq    <= (next_state == ST_LOAD_FIFO);
            inc_addr <= (next_state == ST_STORE);
            if ((next_state == ST_WAIT) && (state != ST_WAIT)) begin
                wait_cnt <= WAIT_CNT_W'(COMP_LAT - 1);
            end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
            end
        end
    end

    assign busy    = rst || (state != ST_IDLE);
    assign hit_inc = match & {NUM_CH{state == ST_DECIDE}};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_hit
        assign hit_clr_ch[g] = hit_clr && (hit_sel == 4'(g));

        sat_counter #(
            .WIDTH(HIT_W)
        ) u_hit (
            .clk  (clk),
            .rst  (rst),
            .inc  (hit_inc[g]),
            .clr  (hit_clr_ch[g]),
            .count(hit_cnt[g])
        );
    end

    sat_counter #(
        .WIDTH(HIT_W)
    ) u_pkt (
        .clk  (clk),
        .rst  (rst),
        .inc  (state == ST_STORE),
        .clr  (1'b0),
        .count(pkt_stored)
    );

    always_comb begin
        hit_count = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (hit_sel == 4'(i)) hit_count = hit_cnt[i];
        end
    end

endmodule

// File: doc/match_controller.md
MATCH_CONTROLLER -- requirements
Module: match_controller

Interface
REQ-001 Parameter NUM_CH, default 4, number of comparator channels (1..16).
REQ-002 Parameter HIT_W, default 32, width of each per-channel hit counter and the packet counter.
REQ-003 Parameter WEIGHT_W, default 4, width of each channel weight.
REQ-004 Parameter COMP_LAT, default 4, comparator pipeline wait cycles after FIFO drain (1..15).
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 update_done  in  1  comparator registers loaded.
REQ-008 ready, eop, error  in  1 each  MAC frame start, end of packet, frame error.
REQ-009 rdempty  in  1  input FIFO empty.
REQ-010 match  in  NUM_CH  per-channel match flags from comparators.
REQ-011 ch_weight  in  NUM_CH*WEIGHT_W  packed weights; channel i at bits [i*WEIGHT_W +: WEIGHT_W].
REQ-012 threshold  in  WEIGHT_W+4  minimum weighted sum for a stored packet.
REQ-013 hit_sel  in  4  channel index for hit_count readout; hit_clr  in  1  clears the selected counter.
REQ-014 rdreq, inc_addr, addr, clear  out  1 each  FIFO read request, address-buffer increment, Avalon config select, comparator flag clear.
REQ-015 hit_count  out  HIT_W  counter of channel hit_sel; zero when hit_sel >= NUM_CH.
REQ-016 pkt_stored  out  HIT_W  count of packets passed to LOAD_MEMORY.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 States: LOAD_CFG, IDLE, LOAD_FIFO, COMPARE, WAIT, DECIDE, STORE, ERROR.
REQ-019 LOAD_CFG->IDLE on update_done; IDLE->LOAD_FIFO on ready.
REQ-020 LOAD_FIFO->COMPARE on eop; else ->ERROR on error; eop wins when both high.
REQ-021 COMPARE->WAIT on rdempty; WAIT holds exactly COMP_LAT cycles via down-counter loaded with COMP_LAT-1, then ->DECIDE.
REQ-022 DECIDE->STORE when weighted sum >= threshold, else ->IDLE; STORE->IDLE after one cycle.
REQ-023 ERROR->IDLE on eop; match is ignored and no counters change on the error path.
REQ-024 Weighted sum = sum over i of (match[i] ? weight_i : 0), computed at WEIGHT_W+4 bits with no overflow; threshold 0 stores every compared packet.
REQ-025 Outputs are registered and decoded from next_state, so each value is valid in the same cycle the state register holds that state.
REQ-026 Output decode: LOAD_CFG addr=1; IDLE clear=1; LOAD_FIFO rdreq=1; DECIDE clear=1; STORE inc_addr=1; all others 0.
REQ-027 On the cycle the FSM is in DECIDE, each channel counter with match[i]=1 increments by 1.
REQ-028 Hit counters and pkt_stored saturate at all-ones and never wrap.
REQ-029 hit_clr zeroes counter hit_sel next cycle; when it coincides with an increment of that channel, clear wins; hit_clr with hit_sel >= NUM_CH has no effect.
REQ-030 pkt_stored increments once per entry into STORE.
REQ-031 hit_count is combinational readout of the selected counter.

Reset
REQ-032 rst asserted at any time forces LOAD_CFG next state; reset value of rdreq, inc_addr, clear, and all counters is 0; reset value of addr is 1; WAIT counter is 0.
REQ-033 While rst is asserted, busy = 1.
REQ-034 Reset mid-packet abandons the packet with no counter update.

Structure
REQ-035 Package match_ctrl_pkg holds the state enum (4 bits) and parameter defaults.
REQ-036 Sub-module sat_counter (parameter WIDTH; ports inc, clr, count) is instantiated once per channel and once for pkt_stored.

Verification
REQ-037 Reset, update_done, ready, 3-cycle packet, eop, rdempty with match=0001, weights=all 1, threshold=1 -> exactly 4 WAIT cycles, one STORE cycle with inc_addr=1, channel 0 hit=1, pkt_stored=1.
REQ-038 match=0110, weights {1,2,3,4} (ch0..3), threshold=6 -> sum 5, no STORE, ch1=ch2=1, pkt_stored unchanged.
REQ-039 error during LOAD_FIFO then eop 5 cycles later -> ERROR then IDLE, no counter changes; error and eop in the same cycle -> COMPARE.
REQ-040 HIT_W=4, 20 matching packets on ch3 -> hit_count saturates at 15.
REQ-041 hit_clr with hit_sel=2 in the DECIDE cycle where match[2]=1 -> ch2 reads 0 afterwards.
REQ-042 rst pulsed during WAIT -> LOAD_CFG with addr=1, all counters 0, busy=1.
